ttc3_aes_ctr_seq: RTL
=====================

TTC3_AES_CTR_SEQ -- requirements
Module: ttc3_aes_ctr_seq

Interface
REQ-001 SHALL have parameter TIMEOUT, default 32: max cycles from aes_start to aes_done before fault.
REQ-002 SHALL have parameter CTR_W, default 32: width of the incrementing low counter field.
REQ-003 clock  input  1  single clock; all logic rising-edge.
REQ-004 reset_n  input  1  synchronous, active-low reset.
REQ-005 cmd_start  input  1  one-cycle pulse; begins a job; accepted only in ST_IDLE.
REQ-006 cmd_abort  input  1  terminates any active job.
REQ-007 cmd_decrypt  input  1  mode bit, sampled on accepted cmd_start.
REQ-008 cmd_nblocks  input  4  block count, sampled on accepted cmd_start; 0 is illegal.
REQ-009 cmd_key  input  128  key, sampled on accepted cmd_start.
REQ-010 cmd_iv  input  128  initial counter block, sampled on accepted cmd_start.
REQ-011 in_valid / in_ready / in_data  input / output / input  1/1/128  valid-ready input block stream.
REQ-012 out_valid / out_ready / out_data  output / input / output  1/1/128  valid-ready result stream.
REQ-013 aes_start  output  1  one-cycle request to the engine.
REQ-014 aes_decrypt / aes_key / aes_plaintext / aes_counter  output  1/128/128/128  engine operands, stable from aes_start until aes_done.
REQ-015 aes_busy / aes_done / aes_ciphertext  input  1/1/128  engine status; ciphertext valid only in the aes_done cycle.
REQ-016 job_busy / job_done / job_err  output  1/1/1  status; job_done and job_err are one-cycle pulses.

Function
REQ-017 States SHALL be: ST_IDLE, ST_WAIT_IN, ST_ISSUE, ST_WAIT_DONE, ST_OUT, ST_ZEROIZE, ST_DONE.
- IDLE -> WAIT_IN on cmd_start with nblocks != 0.
- IDLE -> ZEROIZE on cmd_start with nblocks == 0; job_err set.
- WAIT_IN -> ISSUE on in_valid && in_ready.
- ISSUE -> WAIT_DONE when aes_busy == 0.
- WAIT_DONE -> OUT on aes_done.
- OUT -> WAIT_IN on out handshake with blocks remaining.
- OUT -> ZEROIZE on out handshake of the last block.
- ZEROIZE -> DONE unconditionally.
- DONE -> IDLE unconditionally.
REQ-018 in_ready SHALL be 1 only in ST_WAIT_IN; the accepted block SHALL be latched into the plaintext register.
REQ-019 aes_start SHALL pulse exactly one cycle: the ISSUE cycle in which aes_busy == 0. ISSUE SHALL hold while aes_busy == 1.
REQ-020 aes_ciphertext SHALL be captured in the aes_done cycle into a one-entry output buffer.
REQ-021 out_valid SHALL be 1 only in ST_OUT, and out_data SHALL equal the buffer in every out_valid cycle.
REQ-022 The next block SHALL NOT be requested until the current output handshake completes (no overlap).
REQ-023 Counter increment:
- After each completed block, aes_counter[CTR_W-1:0] SHALL increment by 1 modulo 2^CTR_W.
- aes_counter[127:CTR_W] SHALL never change within a job.
- 0xFFFFFFFF SHALL wrap to 0x00000000 with no carry into the upper bits.
REQ-024 A block-remaining counter SHALL load cmd_nblocks and decrement on each output handshake.
REQ-025 A timeout counter SHALL reset on aes_start and increment in ST_WAIT_DONE. Reaching TIMEOUT SHALL set job_err and force ST_ZEROIZE.
REQ-026 cmd_abort in any non-IDLE state SHALL force ST_ZEROIZE next cycle, set job_err, and drop out_valid.
- An aes_done arriving in that same cycle SHALL be ignored.
- Abort SHALL take priority over all other transitions.
REQ-027 ST_ZEROIZE SHALL clear the key, plaintext, output-buffer and counter registers to 0. aes_key SHALL read 0 in every cycle outside ST_ISSUE and ST_WAIT_DONE.
REQ-028 In ST_DONE:
- job_done SHALL pulse if no error occurred.
- job_err SHALL pulse if any error occurred.
- Never both.
REQ-029 job_busy SHALL be 1 in every state except ST_IDLE.
REQ-030 cmd_start while job_busy SHALL be ignored.

Reset
REQ-031 When reset_n == 0 at a rising edge:
- state SHALL become ST_IDLE.
- All data, key and counter registers SHALL become 0.
- All outputs SHALL become 0, including aes_start, in_ready, out_valid, job_* and all buses.
REQ-032 Reset mid-job SHALL discard the job with no job_done or job_err pulse. aes_done arriving after reset SHALL be ignored.

Structure
REQ-033 The state enum, TIMEOUT default and CTR_W default SHALL reside in shared package ttc3_pkg.
REQ-034 The engine SHALL be instantiated outside this block; this block has no sub-modules.

Verification
REQ-035 The bench SHALL pair this block with ttc3_aes_ctr and the following directed scenarios.
- Basic: nblocks=3, iv=0x...00000005 -> three outputs; aes_counter low word 5, 6, 7; one job_done; key reads 0 after DONE.
- Wrap: iv low word 0xFFFFFFFF, nblocks=2 -> counters 0xFFFFFFFF then 0x00000000; upper 96 bits unchanged.
- Backpressure: out_ready held 0 for 20 cycles -> out_data stable; in_ready stays 0; no second aes_start.
- Timeout: stub engine never asserts aes_done -> job_err exactly TIMEOUT cycles after aes_start (32); no job_done.
- Abort: cmd_abort during ST_WAIT_DONE on block 2 of 4 -> ZEROIZE next cycle; job_err pulse; the late aes_done is ignored.
- Illegal and reset: nblocks=0 -> job_err, no aes_start. reset_n low in ST_OUT -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/ttc3_pkg.sv
// rtl/ttc3_pkg.sv - shared state encoding and parameter defaults for the AES-CTR sequencer
package ttc3_pkg;

    localparam int TIMEOUT_DEF = 32;
    localparam int CTR_W_DEF   = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_IN,
        ST_ISSUE,
        ST_WAIT_DONE,
        ST_OUT,
        ST_ZEROIZE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/ttc3_aes_ctr_seq.sv
// rtl/ttc3_aes_ctr_seq.sv - sequences one block at a time through an external AES engine in counter mode
module ttc3_aes_ctr_seq
    import ttc3_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CTR_W   = CTR_W_DEF
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         cmd_start,
    input  logic         cmd_abort,
    input  logic         cmd_decrypt,
    input  logic [3:0]   cmd_nblocks,
    input  logic [127:0] cmd_key,
    input  logic [127:0] cmd_iv,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         aes_start,
    output logic         aes_decrypt,
    output logic [127:0] aes_key,
    output logic [127:0] aes_plaintext,
    output logic [127:0] aes_counter,
    input  logic         aes_busy,
    input  logic         aes_done,
    input  logic [127:0] aes_ciphertext,
    output logic         job_busy,
    output logic         job_done,
    output logic         job_err
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    state_t           state;
    state_t           state_nxt;
    logic [127:0]     key_q;
    logic [127:0]     pt_q;
    logic [127:0]     obuf_q;
    logic [127:0]     ctr_q;
    logic             mode_q;
    logic             err_q;
    logic [3:0]       rem_q;
    logic [TMO_W-1:0] tmo_q;
    logic             abort_now;
    logic             tmo_hit;
    logic             in_hs;
    logic             out_hs;

    assign abort_now = cmd_abort && (state != ST_IDLE);
    // ZEROIZE and DONE take the last two cycles, so job_err lands exactly TIMEOUT cycles after aes_start
    assign tmo_hit   = (int'(tmo_q) + 3 >= TIMEOUT);
    assign in_hs     = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;

    assign aes_decrypt   = mode_q;
    assign aes_plaintext = pt_q;
    assign aes_counter   = ctr_q;
    assign out_data      = obuf_q;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        aes_start = 1'b0;
        aes_key   = '0;
        job_busy  = (state != ST_IDLE);
        job_done  = 1'b0;
        job_err   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (cmd_start) begin
                    state_nxt = (cmd_nblocks == 4'd0) ? ST_ZEROIZE : ST_WAIT_IN;
                end
            end
            ST_WAIT_IN: begin
                in_ready = !cmd_abort;
                if (in_valid && !cmd_abort) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                aes_key   = key_q;
                aes_start = !aes_busy && !cmd_abort;
                if (!aes_busy) begin
                    state_nxt = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                aes_key = key_q;
                if (aes_done) begin
                    state_nxt = ST_OUT;
                end else if (tmo_hit) begin
                    state_nxt = ST_ZEROIZE;
                end
            end
            ST_OUT: begin
                out_valid = !cmd_abort;
                if (out_ready && !cmd_abort) begin
                    state_nxt = (rem_q == 4'd1) ? ST_ZEROIZE : ST_WAIT_IN;
                end
            end
            ST_ZEROIZE: begin
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                job_done  = !err_q && !cmd_abort;
                job_err   = err_q;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        if (abort_now) begin
            state_nxt = ST_ZEROIZE;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            key_q  <= '0;
            pt_q   <= '0;
            obuf_q <= '0;
            ctr_q  <= '0;
            mode_q <= 1'b0;
            err_q  <= 1'b0;
            rem_q  <= '0;
            tmo_q  <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && cmd_start) begin
                err_q <= (cmd_nblocks == 4'd0);
                if (cmd_nblocks != 4'd0) begin
                    key_q  <= cmd_key;
                    ctr_q  <= cmd_iv;
                    mode_q <= cmd_decrypt;
                    rem_q  <= cmd_nblocks;
                end
            end
            if (in_hs) begin
                pt_q <= in_data;
            end
            if (aes_start) begin
                tmo_q <= '0;
            end else if (state == ST_WAIT_DONE) begin
                tmo_q <= tmo_q + 1'b1;
            end
            if (state == ST_WAIT_DONE && !cmd_abort) begin
                if (aes_done) begin
                    obuf_q <= aes_ciphertext;
                end else if (tmo_hit) begin
                    err_q <= 1'b1;
                end
            end
            if (out_hs) begin
                rem_q              <= rem_q - 4'd1;
                // only the low field counts; the nonce part above it never sees a carry
                ctr_q[CTR_W-1:0]   <= ctr_q[CTR_W-1:0] + 1'b1;
            end
            if (abort_now) begin
                err_q <= 1'b1;
            end
            if (state == ST_ZEROIZE) begin
                key_q  <= '0;
                pt_q   <= '0;
                obuf_q <= '0;
                ctr_q  <= '0;
                mode_q <= 1'b0;
                rem_q  <= '0;
            end
        end
    end

endmodule
